// File: rtl/reg_write_arbiter.sv
// Write-port arbiter for the CRP16 register bank: round-robin grant with a
// bounded lock, registered one-hot write strobe, data bus and per-requester ack.
module reg_write_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 16,
    parameter int MAX_LOCK = 4
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         lock,
    output logic [NUM_REQ-1:0]         ack,
    output logic [NUM_REGS-1:0]        reg_write,
    output logic [DATA_W-1:0]          reg_load_val,
    output logic                       busy,
    output logic                       dbg_state
);

    // Handshake: req[i] acts as a valid that is held, with its addr/data, until
    // ack[i] pulses; the edge closing the ack cycle samples either a dropped req
    // or the requester's next item.

    localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;
    localparam int CNT_W = 4;

    typedef enum logic {
        ST_RR     = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               grant;
    logic               expired;
    logic               honor_lock;
    logic [PTR_W-1:0]   win;
    logic [PTR_W-1:0]   start;
    logic [PTR_W-1:0]   cand;
    int                 rr_idx;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_data;
    logic [NUM_REQ-1:0] ack_d;
    logic [NUM_REGS-1:0] reg_write_d;

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] w);
        if (w == PTR_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return w + PTR_W'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        grant      = 1'b0;
        win        = '0;
        honor_lock = 1'b1;
        start      = ptr_q;
        rr_idx     = 0;
        cand       = '0;
        expired    = (state_q == ST_LOCKED) && (cnt_q >= CNT_W'(MAX_LOCK));

        if ((state_q == ST_LOCKED) && !expired && req[owner_q]) begin
            grant = 1'b1;
            win   = owner_q;
        end else begin
            // An exhausted lock restarts the search just past the owner.
            if (expired) begin
                start      = next_idx(owner_q);
                honor_lock = 1'b0;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                rr_idx = int'(start) + i;
                if (rr_idx >= NUM_REQ) begin
                    rr_idx = rr_idx - NUM_REQ;
                end
                cand = PTR_W'(rr_idx);
                if (!grant && req[cand]) begin
                    grant = 1'b1;
                    win   = cand;
                end
            end
        end

        if (grant) begin
            if (honor_lock && lock[win]) begin
                state_d = ST_LOCKED;
                owner_d = win;
                cnt_d   = ((state_q == ST_LOCKED) && (owner_q == win)) ? cnt_q + CNT_W'(1)
                                                                       : CNT_W'(1);
            end else begin
                state_d = ST_RR;
                cnt_d   = '0;
                ptr_d   = next_idx(win);
            end
        end else if ((state_q == ST_LOCKED) && !req[owner_q]) begin
            state_d = ST_RR;
            cnt_d   = '0;
        end
    end

    always_comb begin
        win_addr    = '0;
        win_data    = '0;
        ack_d       = '0;
        reg_write_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == win) begin
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
        if (grant) begin
            ack_d[win]            = 1'b1;
            reg_write_d[win_addr] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_RR;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strobes last exactly one cycle; the data bus holds its last value when idle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ack          <= '0;
            reg_write    <= '0;
            reg_load_val <= '0;
            busy         <= 1'b0;
        end else begin
            ack       <= ack_d;
            reg_write <= reg_write_d;
            busy      <= grant;
            if (grant) begin
                reg_load_val <= win_data;
            end
        end
    end

    assign dbg_state = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: stimulus pushes expected grants into a
// queue, a negedge monitor pops and compares them whenever an ack appears.
module tb_reg_write_arbiter;

    localparam int EXP_W = 16 + 3 + 8 + 16;

    logic        clock;
    logic        resetn;
    logic [2:0]  req;
    logic [2:0]  lock;
    logic [8:0]  req_addr;
    logic [47:0] req_data;
    logic [2:0]  ack;
    logic [7:0]  reg_write;
    logic [15:0] reg_load_val;
    logic        busy;
    logic        dbg_state;

    logic [2:0]  addr_a [3];
    logic [15:0] data_a [3];
    logic [15:0] bank   [8];

    logic [EXP_W-1:0] exp_q[$];
    int cyc;
    int tests_run;
    int tests_failed;

    assign req_addr = {addr_a[2], addr_a[1], addr_a[0]};
    assign req_data = {data_a[2], data_a[1], data_a[0]};

    reg_write_arbiter #(
        .NUM_REQ (3),
        .NUM_REGS(8),
        .ADDR_W  (3),
        .DATA_W  (16),
        .MAX_LOCK(4)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .req         (req),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .lock        (lock),
        .ack         (ack),
        .reg_write   (reg_write),
        .reg_load_val(reg_load_val),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // clock / reset block
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Bank of register_16_bit stand-ins
    always @(posedge clock) begin
        for (int i = 0; i < 8; i++) begin
            if (reg_write[i]) bank[i] <= reg_load_val;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic push_exp(input logic [2:0] a, input logic [7:0] rw, input logic [15:0] d);
        exp_q.push_back({16'(cyc + 1), a, rw, d});
    endtask

    task automatic push_grant(input int w);
        logic [7:0] rw;
        logic [2:0] a;
        rw = 8'b1 << addr_a[w];
        a  = 3'b001 << w;
        push_exp(a, rw, data_a[w]);
    endtask

    task automatic do_reset();
        tick();
        resetn = 1'b0;
        req    = 3'b000;
        lock   = 3'b000;
        tick();
        resetn = 1'b1;
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        logic [EXP_W-1:0] e;
        if (resetn) begin
            check("busy_vs_write", {31'b0, busy}, {31'b0, |reg_write});
            check("write_onehot0", {31'b0, $onehot0(reg_write)}, 32'd1);
            if (ack != 3'b000) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_ack: got %0b expected none (t=%0t)", ack, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_cycle", 32'(cyc[15:0]), 32'(e[42:27]));
                    check("ack", 32'(ack), 32'(e[26:24]));
                    check("reg_write", 32'(reg_write), 32'(e[23:16]));
                    check("load_val", 32'(reg_load_val), 32'(e[15:0]));
                end
            end
        end
    end

    int win_lock [7];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        req    = 3'b000;
        lock   = 3'b000;
        for (int i = 0; i < 3; i++) begin
            addr_a[i] = '0;
            data_a[i] = '0;
        end
        for (int i = 0; i < 8; i++) bank[i] = '0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_reg_write", 32'(reg_write), 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_load_val", 32'(reg_load_val), 32'd0);
        check("rst_state", {31'b0, dbg_state}, 32'd0);
        repeat (2) tick();
        resetn = 1'b1;

        // Single request: R5 <= BEEF
        tick();
        addr_a[0] = 3'd5;
        data_a[0] = 16'hBEEF;
        req = 3'b001;
        push_exp(3'b001, 8'b0010_0000, 16'hBEEF);
        tick();
        req = 3'b000;
        repeat (2) tick();
        check("bank_r5", 32'(bank[5]), 32'h0000_BEEF);

        // Fairness from reset: 0,1,2,0,1,2 with no gaps
        do_reset();
        addr_a[0] = 3'd1; data_a[0] = 16'hA000;
        addr_a[1] = 3'd2; data_a[1] = 16'hA001;
        addr_a[2] = 3'd4; data_a[2] = 16'hA002;
        for (int k = 0; k < 6; k++) begin
            tick();
            req = 3'b111;
            push_grant(k % 3);
        end
        tick();
        req = 3'b000;

        // Lock bound: grant 0 first so the pointer sits at 1, then 1 locks
        do_reset();
        addr_a[0] = 3'd6; data_a[0] = 16'hC000;
        addr_a[1] = 3'd0; data_a[1] = 16'hC001;
        addr_a[2] = 3'd7; data_a[2] = 16'hC002;
        tick();
        req = 3'b001;
        push_grant(0);
        win_lock = '{1, 1, 1, 1, 2, 0, 1};
        for (int k = 0; k < 7; k++) begin
            tick();
            req  = 3'b111;
            lock = 3'b010;
            push_grant(win_lock[k]);
        end
        tick();
        check("relocked_state", {31'b0, dbg_state}, 32'd1);
        req  = 3'b000;
        lock = 3'b000;
        tick();
        check("lock_released", {31'b0, dbg_state}, 32'd0);

        // Owner drop: 0 locked twice, then drops while 2 requests
        do_reset();
        addr_a[0] = 3'd2; data_a[0] = 16'h0D00;
        addr_a[2] = 3'd1; data_a[2] = 16'h0D02;
        tick();
        req  = 3'b001;
        lock = 3'b001;
        push_grant(0);
        tick();
        push_grant(0);
        tick();
        check("owner_locked", {31'b0, dbg_state}, 32'd1);
        req  = 3'b100;
        lock = 3'b000;
        push_grant(2);
        tick();
        req = 3'b000;
        check("owner_drop_rr", {31'b0, dbg_state}, 32'd0);

        // Same-register collision on R3
        do_reset();
        addr_a[0] = 3'd3; data_a[0] = 16'h1111;
        addr_a[1] = 3'd3; data_a[1] = 16'h2222;
        tick();
        req = 3'b011;
        push_exp(3'b001, 8'h08, 16'h1111);
        tick();
        req = 3'b010;
        push_exp(3'b010, 8'h08, 16'h2222);
        tick();
        req = 3'b000;
        repeat (2) tick();
        check("bank_r3", 32'(bank[3]), 32'h0000_2222);

        // Reset while a strobe is high
        do_reset();
        addr_a[0] = 3'd1; data_a[0] = 16'h6000;
        addr_a[1] = 3'd4; data_a[1] = 16'h6001;
        addr_a[2] = 3'd5; data_a[2] = 16'h6002;
        tick();
        req = 3'b010;
        push_grant(1);
        tick();
        req = 3'b111;
        @(posedge clock);
        #1;
        check("pre_reset_ack", 32'(ack), 32'b100);
        check("pre_reset_write", 32'(reg_write), 32'h20);
        #1 resetn = 1'b0;
        #1;
        check("async_ack", 32'(ack), 32'd0);
        check("async_write", 32'(reg_write), 32'd0);
        check("async_busy", {31'b0, busy}, 32'd0);
        check("async_load_val", 32'(reg_load_val), 32'd0);
        repeat (2) tick();
        resetn = 1'b1;
        push_grant(0);
        tick();
        req = 3'b000;
        repeat (3) tick();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write-port arbiter and sequencer for the CRP16 16-bit register bank. Up to four requesters (ALU writeback, memory load, interrupt/debug, etc.) compete for the bank's single write path. Each cycle the block grants one requester, registers its address and data, and drives a one-hot write strobe into the bank's `register_16_bit` instances (their `write` and `load_val` inputs). A bounded lock lets a requester own the port for back-to-back writes without starving the others.

## Interface
- `NUM_REQ`, 3: number of requesters; legal range 2..4.
- `NUM_REGS`, 8: registers in the bank; power of two, 2..16.
- `ADDR_W`, 3: register address width; equals log2(`NUM_REGS`).
- `DATA_W`, 16: data width.
- `MAX_LOCK`, 4: maximum consecutive grants to one locked requester; range 1..15.

- `clock`  in  1  single clock; all state updates on its posedge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req`  in  `NUM_REQ`  per-requester write request.
- `req_addr`  in  `NUM_REQ*ADDR_W`  packed target addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- `req_data`  in  `NUM_REQ*DATA_W`  packed write data; requester i occupies bits [i*DATA_W +: DATA_W].
- `lock`  in  `NUM_REQ`  requester wants to keep the port after its current grant.
- `ack`  out  `NUM_REQ`  one-hot, one-cycle pulse: this requester's write is being performed this cycle.
- `reg_write`  out  `NUM_REGS`  one-hot write enables to the bank.
- `reg_load_val`  out  `DATA_W`  data bus to every register's `load_val`.
- `busy`  out  1  high when any write is in flight this cycle (OR of `reg_write`).

## Operation
- The state machine has two states.
  - IDLE/RR: normal round-robin operation.
  - LOCKED: one owner holds priority.
- Round-robin pointer `ptr` (0..`NUM_REQ`-1):
  - The search starts at `ptr` and wraps modulo `NUM_REQ`.
  - After a grant to requester w in RR, `ptr` becomes (w+1) mod `NUM_REQ`.
- Grant at each posedge when any `req` bit is high:
  - In RR, the winner is the first requester with `req` high at or after `ptr`.
  - In LOCKED, the winner is the owner if its `req` is high. Otherwise the block falls back to RR and returns to RR.
- On a grant, register the following for exactly one cycle:
  - `reg_load_val` <= winner's data.
  - `reg_write` <= decode(winner's address).
  - `ack[w]` <= 1.
  - All other strobes <= 0.
- Lock handling:
  - If the winner's `lock` bit is high at the granting edge, go to LOCKED, set owner = w, and increment `lock_cnt`. `ptr` is not advanced.
  - When `lock_cnt` reaches `MAX_LOCK`, the next arbitration ignores the lock. It is done as RR with `ptr` = (owner+1) mod `NUM_REQ`, and `lock_cnt` clears.
  - A grant without `lock`, or an owner drop, also clears `lock_cnt` and returns to RR.
- With no request, all strobes are 0 next cycle. State, `ptr` and `lock_cnt` hold, except that LOCKED with the owner's `req` low returns to RR.
- Requester protocol:
  - Hold `req`/`addr`/`data` stable until `ack` is seen.
  - In the `ack` cycle, either drop `req` or present the next item. It is sampled at the closing edge.
- Only one register is written per cycle. Different requesters addressing the same register are serialized in grant order.
- Reset (`resetn` low, at any time and asynchronously) forces:
  - `ack`, `reg_write`, `busy` = 0 and `reg_load_val` = 0.
  - `ptr` = 0, `lock_cnt` = 0, state = RR.
  - An in-flight strobe is killed immediately. Bank contents are not reset by this block.

## Timing
- Latency: a request sampled at edge k produces `reg_write`/`ack` during cycle k..k+1. The bank captures at edge k+1.
- Sustained throughput is one write per cycle.
- Worst-case wait for a non-locked requester is (`NUM_REQ`-1)·`MAX_LOCK` + (`NUM_REQ`-1) grants.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset release is synchronous to the next posedge. The first grant can occur at the first posedge with `resetn` high.

## Test plan
- Single request: `req`=001, addr=5, data=16'hBEEF.
  - Response: the next cycle has `reg_write`=8'b0010_0000, `reg_load_val`=BEEF, `ack`=001, `busy`=1, and the bank's R5 reads BEEF afterwards.
- Fairness: all three `req` held continuously with no lock, from reset.
  - Response: `ack` sequence 001,010,100,001,… with no gaps.
- Lock bound: requester 1 holds `req`+`lock`, others request, `MAX_LOCK`=4.
  - Response: four consecutive `ack`=010, then 100, then 001, then 010 resumes.
- Owner drop: requester 0 is LOCKED and drops `req` while requester 2 requests.
  - Response: the next grant is `ack`=100 and the state returns to RR.
- Same-register collision: requesters 0 and 1 both target R3, with data 1111 and 2222, `ptr`=0.
  - Response: two consecutive writes, R3 ends at 2222, and `reg_write` is never multi-hot.
- Reset mid-operation: `resetn` asserted while `reg_write` is high.
  - Response: strobes drop to 0 immediately without waiting for a clock edge. After release, the first grant goes to requester 0.
